// File: rtl/pipe_reg_pkg.sv
// Shared helpers for the pipeline register chain: width math and default reset value.
package pipe_reg_pkg;

  localparam int unsigned RESET_VAL_DFLT = 0;

  // Ceiling log2 for elaboration-time width math; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Width of a counter that must hold 0..depth inclusive, never narrower than one bit.
  function automatic int unsigned occ_w(input int unsigned depth);
    int unsigned w;
    w = clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline slot: data + valid register with load, flush and synchronous reset.
// Data only changes when a valid word is loaded, so bubbles never toggle the data bits.
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 7,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             stage_vld,
  output logic [WIDTH-1:0] stage_data
);

  logic             vld_q;
  logic             vld_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next-state: flush empties the slot and freezes data; otherwise load from upstream.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  // Slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      data_q <= RESET_VAL;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign stage_vld  = vld_q;
  assign stage_data = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain with valid/ready handshake, bubble collapse and flush.
// Optional feature macro: PIPE_REG_OCC_COUNT_EN adds a registered occupancy count output.
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 7,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DFLT)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data
`ifdef PIPE_REG_OCC_COUNT_EN
  ,
  output logic [occ_w(DEPTH)-1:0]   occupancy
`endif
);

  // Reject degenerate configurations at elaboration.
  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end
  if (WIDTH < 1) begin : g_width_check
    $error("pipe_reg_chain: WIDTH must be at least 1");
  end

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0]            up_vld;
  logic [DEPTH-1:0][WIDTH-1:0] up_data;
  logic [DEPTH-1:0]            rdy_c;
  logic                        rdy_acc;

  // Ready ripples from the output back to the input; any empty slot absorbs a stall.
  always_comb begin
    rdy_c   = '0;
    rdy_acc = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      rdy_acc  = ~vld[k] | rdy_acc;
      rdy_c[k] = rdy_acc;
    end
  end

  // Stage k is fed by the producer (k=0) or by stage k-1.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_vld[k]  = in_valid;
      assign up_data[k] = in_data;
    end else begin : g_body
      assign up_vld[k]  = vld[k-1];
      assign up_data[k] = data[k-1];
    end

    pipe_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .load       (rdy_c[k]),
      .up_valid   (up_vld[k]),
      .up_data    (up_data[k]),
      .stage_vld  (vld[k]),
      .stage_data (data[k])
    );
  end

  // Producer side is held off while reset is asserted; flush does not mask ready.
  assign in_ready  = reset_n & rdy_c[0];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];

`ifdef PIPE_REG_OCC_COUNT_EN
  localparam int unsigned OCC_W = occ_w(DEPTH);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             in_fire_c;
  logic             out_fire_c;

  // Occupancy tracks the number of set valid bits, updated on the same edge.
  always_comb begin
    in_fire_c  = in_valid & in_ready;
    out_fire_c = out_valid & out_ready;
    occ_d      = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_fire_c && !out_fire_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_fire_c && out_fire_c) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=7, DEPTH=3) with a word-queue reference model.
// Occupancy checks are compiled in when PIPE_REG_OCC_COUNT_EN is defined.
module tb_pipe_reg_chain;

  localparam int WIDTH = 7;
  localparam int DEPTH = 3;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             in_ready2;
  logic             out_valid2;
  logic [WIDTH-1:0] out_data2;
`ifdef PIPE_REG_OCC_COUNT_EN
  logic [1:0]       occupancy;
  logic [1:0]       occupancy2;
`endif

  int checks = 0;
  int errors = 0;

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(7'h00)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_OCC_COUNT_EN
    ,
    .occupancy (occupancy)
`endif
  );

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(7'h2A)) dut_rv (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2)
`ifdef PIPE_REG_OCC_COUNT_EN
    ,
    .occupancy (occupancy2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered queue of words, each with its slot position (-1 = just offered).
  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } ent_t;

  ent_t             mq[$];
  logic [WIDTH-1:0] m_last = 7'h00;
  bit               m_ir;
  int               m_lim;
  int               m_np;
  ent_t             m_e;

  function automatic bit m_out_valid();
    return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
  endfunction

  function automatic bit m_in_ready();
    return reset_n && ((mq.size() < DEPTH) || out_ready);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_last = 7'h00;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_ir = (mq.size() < DEPTH) || out_ready;
      if (mq.size() > 0 && mq[0].pos == DEPTH - 1 && out_ready) void'(mq.pop_front());
      if (in_valid && m_ir) begin
        m_e.data = in_data;
        m_e.pos  = -1;
        mq.push_back(m_e);
      end
      // Each word advances one slot unless the word ahead of it blocks.
      m_lim = DEPTH;
      foreach (mq[i]) begin
        m_np = (mq[i].pos + 1 < m_lim - 1) ? mq[i].pos + 1 : m_lim - 1;
        if (m_np == DEPTH - 1 && mq[i].pos != DEPTH - 1) m_last = mq[i].data;
        mq[i].pos = m_np;
        m_lim     = m_np;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 7'h55; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_pre got %b exp 0", in_ready); end
    repeat (2) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++;
      if (out_data !== 7'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      checks++;
      if (out_data2 !== 7'h2A) begin errors++; $display("FAIL reset_val_out_data got %h exp 2a", out_data2); end
`ifdef PIPE_REG_OCC_COUNT_EN
      checks++;
      if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
`endif
    end
    reset_n = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] got[$];
    int first_out = -1;
    int last_out  = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 10);
      in_data  = 7'(c + 1);
      #1;
      if (c < 10) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got %b exp 1", c, in_ready); end
      end
      tick();
      checks++;
      if (out_valid !== m_out_valid()) begin
        errors++; $display("FAIL stream_out_valid c=%0d got %b exp %b", c, out_valid, m_out_valid());
      end
      if (out_valid === 1'b1) begin
        if (first_out < 0) first_out = c + 1;
        last_out = c + 1;
        got.push_back(out_data);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (first_out !== 3) begin errors++; $display("FAIL stream_latency got %0d exp 3", first_out); end
    checks++;
    if (last_out - first_out !== 9) begin errors++; $display("FAIL stream_gapless got %0d exp 9", last_out - first_out); end
    checks++;
    if (got.size() !== 10) begin errors++; $display("FAIL stream_count got %0d exp 10", got.size()); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      checks++;
      if (got[i] !== 7'(i + 1)) begin errors++; $display("FAIL stream_data i=%0d got %h exp %h", i, got[i], 7'(i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] vals[4];
    logic [WIDTH-1:0] got[$];
    bit acc;
    vals[0] = 7'h11; vals[1] = 7'h22; vals[2] = 7'h33; vals[3] = 7'h44;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      #1;
      checks++;
      if (in_ready !== (i < 3)) begin errors++; $display("FAIL bp_in_ready i=%0d got %b exp %b", i, in_ready, (i < 3)); end
      if (i < 3) tick();
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h11) begin
        errors++; $display("FAIL bp_hold c=%0d got %b/%h exp 1/11", c, out_valid, out_data);
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b exp 0", in_ready); end
`ifdef PIPE_REG_OCC_COUNT_EN
      checks++;
      if (occupancy !== 2'd3) begin errors++; $display("FAIL bp_occupancy got %0d exp 3", occupancy); end
`endif
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid === 1'b1) got.push_back(out_data);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (got.size() !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] !== vals[i]) begin errors++; $display("FAIL bp_order i=%0d got %h exp %h", i, got[i], vals[i]); end
    end
  endtask

  task automatic test_bubbles();
    logic [WIDTH-1:0] got[$];
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = (i == 0) ? 7'h21 : 7'h42;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_in_ready i=%0d got %b exp 1", i, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h21) begin
      errors++; $display("FAIL bub_head got %b/%h exp 1/21", out_valid, out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_two_held_in_ready got %b exp 1", in_ready); end
`ifdef PIPE_REG_OCC_COUNT_EN
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL bub_occupancy got %0d exp 2", occupancy); end
`endif
    in_valid = 1'b1; in_data = 7'h63;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bub_three_held_in_ready got %b exp 0", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid === 1'b1) got.push_back(out_data);
      tick();
    end
    checks++;
    if (got.size() !== 3 || got[0] !== 7'h21 || got[1] !== 7'h42 || got[2] !== 7'h63) begin
      errors++; $display("FAIL bub_drain got n=%0d exp 21,42,63", got.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 7'(5 + i);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 7'h7F;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    checks++;
    if (out_data !== 7'h05) begin errors++; $display("FAIL flush_data_kept got %h exp 05", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
`ifdef PIPE_REG_OCC_COUNT_EN
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occupancy got %0d exp 0", occupancy); end
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped c=%0d got %b/%h exp 0", c, out_valid, out_data); end
    end
  endtask

  task automatic test_mid_reset();
    int first_out = -1;
    logic [WIDTH-1:0] first_data = 7'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 7'(10 + i);
      tick();
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 7'h00) begin
      errors++; $display("FAIL midrst_empty got %b/%h exp 0/00", out_valid, out_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
`ifdef PIPE_REG_OCC_COUNT_EN
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL midrst_occupancy got %0d exp 0", occupancy); end
`endif
    reset_n = 1'b1; in_valid = 1'b1; in_data = 7'h3C; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_accept got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 8; c++) begin
      if (out_valid === 1'b1 && first_out < 0) begin first_out = c; first_data = out_data; end
      tick();
    end
    checks++;
    if (first_out !== 3 || first_data !== 7'h3C) begin
      errors++; $display("FAIL midrst_latency got %0d/%h exp 3/3c", first_out, first_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset_n   = ($urandom_range(0, 59) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 7'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (in_ready !== m_in_ready()) begin
        errors++; $display("FAIL rand_in_ready c=%0d got %b exp %b", c, in_ready, m_in_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_out_valid()) begin
        errors++; $display("FAIL rand_out_valid c=%0d got %b exp %b", c, out_valid, m_out_valid());
      end
      checks++;
      if (out_data !== m_last) begin
        errors++; $display("FAIL rand_out_data c=%0d got %h exp %h", c, out_data, m_last);
      end
`ifdef PIPE_REG_OCC_COUNT_EN
      checks++;
      if (int'(occupancy) !== mq.size()) begin
        errors++; $display("FAIL rand_occupancy c=%0d got %0d exp %0d", c, occupancy, mq.size());
      end
`endif
    end
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
